// File: rtl/branch_cmp_pipe_pkg.sv
// Shared definitions for the pipelined branch comparator: condition codes and
// the partial-compare bundle passed from the split stage into S1.
package branch_cmp_pipe_pkg;

    // Condition codes; the legacy 3-bit codes keep a leading zero.
    localparam logic [3:0] CMP_NE  = 4'b0000;
    localparam logic [3:0] CMP_EQ  = 4'b0001;
    localparam logic [3:0] CMP_LT  = 4'b0010;
    localparam logic [3:0] CMP_LTU = 4'b0011;
    localparam logic [3:0] CMP_LTZ = 4'b0100;
    localparam logic [3:0] CMP_GEZ = 4'b0101;
    localparam logic [3:0] CMP_LEZ = 4'b0110;
    localparam logic [3:0] CMP_GTZ = 4'b0111;
    localparam logic [3:0] CMP_GE  = 4'b1010;
    localparam logic [3:0] CMP_GEU = 4'b1011;

    // Half-split partial compare results.
    typedef struct packed {
        logic eq_hi;
        logic eq_lo;
        logic ltu_hi;
        logic ltu_lo;
        logic a_msb;
        logic b_msb;
        logic zhi;
        logic zlo;
    } cmp_part_t;

endpackage

// File: rtl/cmp_split_stage.sv
// Combinational half-split compare: each half is compared independently so
// the carry chain seen before the S1 register is only WIDTH/2 long.
module cmp_split_stage
    import branch_cmp_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output cmp_part_t        part_o
);

    localparam int unsigned HALF = WIDTH / 2;

    logic [HALF-1:0] a_hi, a_lo, b_hi, b_lo;

    assign a_hi = a_i[WIDTH-1:HALF];
    assign a_lo = a_i[HALF-1:0];
    assign b_hi = b_i[WIDTH-1:HALF];
    assign b_lo = b_i[HALF-1:0];

    // Per-half unsigned compares plus sign bits and zero detects of A.
    always_comb begin
        part_o        = '0;
        part_o.eq_hi  = (a_hi == b_hi);
        part_o.eq_lo  = (a_lo == b_lo);
        part_o.ltu_hi = (a_hi < b_hi);
        part_o.ltu_lo = (a_lo < b_lo);
        part_o.a_msb  = a_i[WIDTH-1];
        part_o.b_msb  = b_i[WIDTH-1];
        part_o.zhi    = (a_hi == '0);
        part_o.zlo    = (a_lo == '0);
    end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Two-stage pipelined branch/set comparator with valid/ready handshake,
// flush, and a saturating count of taken results.
module branch_cmp_pipe
    import branch_cmp_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_ctrl_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [CNT_W-1:0] taken_count_o
);

    cmp_part_t part;

    cmp_split_stage #(
        .WIDTH (WIDTH)
    ) u_split (
        .a_i    (in_a_i),
        .b_i    (in_b_i),
        .part_o (part)
    );

    // S1 state
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       s1_ctrl_q;
    logic [TAG_W-1:0] s1_tag_q;
    cmp_part_t        s1_part_q;

    // S2 (output) state
    logic             out_valid_q, out_valid_d;
    logic             out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic s2_adv, s1_adv, in_fire, out_fire, s2_load, cmp_res;
    logic eq, ltu, lts, zero;

    // Handshake: a stage may advance when the stage after it is free or draining.
    always_comb begin
        s2_adv     = !out_valid_q || out_ready_i;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready_o = s1_adv && !flush_i && !reset_i;
        in_fire    = in_valid_i && in_ready_o;
        out_fire   = out_valid_q && out_ready_i;
        s2_load    = s2_adv && s1_valid_q && !flush_i;
    end

    // Combine the registered partial compares and select by condition code.
    always_comb begin
        eq   = s1_part_q.eq_hi && s1_part_q.eq_lo;
        ltu  = s1_part_q.ltu_hi || (s1_part_q.eq_hi && s1_part_q.ltu_lo);
        lts  = (s1_part_q.a_msb ^ s1_part_q.b_msb) ? s1_part_q.a_msb : ltu;
        zero = s1_part_q.zhi && s1_part_q.zlo;
        unique case (s1_ctrl_q)
            CMP_EQ:  cmp_res = eq;
            CMP_NE:  cmp_res = !eq;
            CMP_LT:  cmp_res = lts;
            CMP_LTU: cmp_res = ltu;
            CMP_GE:  cmp_res = !lts;
            CMP_GEU: cmp_res = !ltu;
            CMP_LEZ: cmp_res = s1_part_q.a_msb || zero;
            CMP_LTZ: cmp_res = s1_part_q.a_msb;
            CMP_GTZ: cmp_res = !s1_part_q.a_msb && !zero;
            CMP_GEZ: cmp_res = !s1_part_q.a_msb;
            default: cmp_res = 1'b0;
        endcase
    end

    // Next-state for valid bits, output register and taken counter.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_tag_d     = out_tag_q;
        taken_count_d = taken_count_q;

        if (s1_adv) s1_valid_d = in_fire;
        if (s2_adv) out_valid_d = s1_valid_q;
        if (s2_load) begin
            out_result_d = cmp_res;
            out_tag_d    = s1_tag_q;
        end
        // A transfer completing in a flush cycle still counts.
        if (out_fire && out_result_q && !(&taken_count_q)) begin
            taken_count_d = taken_count_q + CNT_W'(1);
        end

        if (flush_i) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
        if (reset_i) begin
            s1_valid_d    = 1'b0;
            out_valid_d   = 1'b0;
            out_result_d  = 1'b0;
            out_tag_d     = '0;
            taken_count_d = '0;
        end
    end

    // Control and output registers with synchronous reset folded into _d.
    always_ff @(posedge clk_i) begin
        s1_valid_q    <= s1_valid_d;
        out_valid_q   <= out_valid_d;
        out_result_q  <= out_result_d;
        out_tag_q     <= out_tag_d;
        taken_count_q <= taken_count_d;
    end

    // S1 data capture; needs no reset because s1_valid_q qualifies it.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            s1_ctrl_q <= in_ctrl_i;
            s1_tag_q  <= in_tag_i;
            s1_part_q <= part;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_result_o  = out_result_q;
    assign out_tag_o     = out_tag_q;
    assign taken_count_o = taken_count_q;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Bench for branch_cmp_pipe: a 32-bit instance checked every cycle against a
// transaction-level model, plus an 8-bit/3-bit-counter instance for
// saturation and mid-stream reset.
module tb_branch_cmp_pipe;
    import branch_cmp_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]  in_ctrl = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid, out_result;
    logic [4:0]  out_tag;
    logic [15:0] taken_count;

    branch_cmp_pipe #(.WIDTH(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk_i (clk), .reset_i (reset), .flush_i (flush),
        .in_valid_i (in_valid), .in_ready_o (in_ready), .in_ctrl_i (in_ctrl),
        .in_a_i (in_a), .in_b_i (in_b), .in_tag_i (in_tag),
        .out_valid_o (out_valid), .out_ready_i (out_ready), .out_result_o (out_result),
        .out_tag_o (out_tag), .taken_count_o (taken_count)
    );

    // 8-bit instance with a 3-bit counter
    logic       s_reset = 1'b1, s_in_valid = 1'b0;
    logic [7:0] s_a = '0, s_b = '0;
    logic [4:0] s_tag = '0;
    logic       s_in_ready, s_out_valid, s_out_result;
    logic [4:0] s_out_tag;
    logic [2:0] s_taken;

    branch_cmp_pipe #(.WIDTH(8), .TAG_W(5), .CNT_W(3)) dut_small (
        .clk_i (clk), .reset_i (s_reset), .flush_i (1'b0),
        .in_valid_i (s_in_valid), .in_ready_o (s_in_ready), .in_ctrl_i (CMP_EQ),
        .in_a_i (s_a), .in_b_i (s_b), .in_tag_i (s_tag),
        .out_valid_o (s_out_valid), .out_ready_i (1'b1), .out_result_o (s_out_result),
        .out_tag_o (s_out_tag), .taken_count_o (s_taken)
    );

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition semantics on whole operands.
    function automatic logic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0001: return a == b;
            4'b0000: return a != b;
            4'b0010: return $signed(a) < $signed(b);
            4'b0011: return a < b;
            4'b1010: return $signed(a) >= $signed(b);
            4'b1011: return a >= b;
            4'b0110: return $signed(a) <= 32'sd0;
            4'b0100: return $signed(a) < 32'sd0;
            4'b0111: return $signed(a) > 32'sd0;
            4'b0101: return $signed(a) >= 32'sd0;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [4:0] tag;
        logic       res;
        int         acc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0, pops = 0;
    logic [15:0] cnt_m = '0;
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0, prev_res = 1'b0;
    logic [4:0]  prev_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare the 32-bit instance with the model, then predict the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", out_valid, q.size() > 0 && (cyc - q[0].acc) >= 2);
            if (out_valid && q.size() > 0) begin
                check("out_result", out_result, q[0].res);
                check("out_tag", out_tag, q[0].tag);
            end
            check("in_ready", in_ready, !reset && !flush && !(q.size() == 2 && !out_ready));
            check("taken_count", taken_count, cnt_m);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_result", out_result, prev_res);
                check("stall_tag", out_tag, prev_tag);
            end
            prev_stall = out_valid && !out_ready && !reset && !flush;
            prev_res   = out_result;
            prev_tag   = out_tag;

            if (reset) begin
                q.delete();
                cnt_m = '0;
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    if (q[0].res && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
                    void'(q.pop_front());
                    pops++;
                end
                if (flush) q.delete();
                else if (in_valid && in_ready)
                    q.push_back('{tag: in_tag, res: model(in_ctrl, in_a, in_b), acc: cyc});
            end
        end
    end

    // One op on an idle pipe with literal expectation and latency check.
    task automatic single(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input logic e);
        @(posedge clk); #1;
        in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_cycle1_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", out_valid, 1'b1);
        check("lit_result", out_result, e);
        check("lit_tag", out_tag, t);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic        e;
    } vec_t;

    vec_t vecs[$] = '{
        '{CMP_LT,  32'hFFFFFFFF, 32'h1, 1'b1}, '{CMP_LTU, 32'hFFFFFFFF, 32'h1, 1'b0},
        '{CMP_GE,  32'hFFFFFFFF, 32'h1, 1'b0}, '{CMP_GEU, 32'hFFFFFFFF, 32'h1, 1'b1},
        '{CMP_EQ,  32'hFFFFFFFF, 32'h1, 1'b0}, '{CMP_NE,  32'hFFFFFFFF, 32'h1, 1'b1},
        '{CMP_LTU, 32'h00010000, 32'h0000FFFF, 1'b0},
        '{CMP_GEU, 32'h00010000, 32'h0000FFFF, 1'b1},
        '{CMP_EQ,  32'h00010000, 32'h0000FFFF, 1'b0},
        '{CMP_EQ,  32'h12345678, 32'h12345678, 1'b1},
        '{CMP_LT,  32'h12345678, 32'h12345678, 1'b0},
        '{CMP_GE,  32'h12345678, 32'h12345678, 1'b1},
        '{CMP_LEZ, 32'h0, 32'h7, 1'b1}, '{CMP_LTZ, 32'h0, 32'h7, 1'b0},
        '{CMP_GTZ, 32'h0, 32'h7, 1'b0}, '{CMP_GEZ, 32'h0, 32'h7, 1'b1},
        '{CMP_LTZ, 32'h80000000, 32'h0, 1'b1}, '{CMP_GEZ, 32'h80000000, 32'h0, 1'b0},
        '{CMP_GTZ, 32'h5, 32'hFFFFFFFF, 1'b1}, '{CMP_LEZ, 32'h5, 32'hFFFFFFFF, 1'b0},
        '{4'b1111, 32'h5, 32'h5, 1'b0}, '{4'b1000, 32'h5, 32'h5, 1'b0}
    };

    int   idx, pops0;
    logic acc_flag, saw_block;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 1'b0);
        check("rst_out_tag", out_tag, 5'd0);
        check("rst_taken", taken_count, 16'd0);
        mon_en = 1'b1;
        reset = 1'b0;

        // Directed compares
        foreach (vecs[i]) single(vecs[i].c, vecs[i].a, vecs[i].b, 5'(i), vecs[i].e);

        // Backpressure: 5 ops streamed, consumer stalls for 3 cycles
        @(posedge clk); #1;
        pops0 = pops; idx = 0; acc_flag = 1'b0; saw_block = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (acc_flag) idx++;
            out_ready = !(k >= 3 && k <= 5);
            if (idx < 5) begin
                in_valid = 1'b1; in_ctrl = CMP_LTU; in_a = 32'(idx); in_b = 32'd3;
                in_tag = 5'(10 + idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc_flag = in_valid && in_ready;
            if (in_valid && !in_ready) saw_block = 1'b1;
        end
        check("bp_in_ready_dropped", saw_block, 1'b1);
        check("bp_all_delivered", pops - pops0, 5);
        check("bp_queue_empty", q.size(), 0);

        // Flush with both stages full and a new op offered
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = CMP_EQ; in_a = 32'h9; in_b = 32'h9;
        in_tag = 5'd20;
        @(posedge clk); #1;
        in_tag = 5'd21;
        @(posedge clk); #1;
        in_tag = 5'd22; flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", out_valid, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check("flush_no_ghost", out_valid, 1'b0);
        end
        single(CMP_EQ, 32'h9, 32'h9, 5'd23, 1'b1);

        // Flush while the head transfers: that result still counts
        @(posedge clk); #1;
        in_valid = 1'b1; in_ctrl = CMP_EQ; in_tag = 5'd24;
        @(posedge clk); #1;
        in_tag = 5'd25;
        @(posedge clk); #1;
        in_tag = 5'd26; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("end_queue_empty", q.size(), 0);

        // Small instance: counter saturation then mid-stream reset
        s_reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            s_in_valid = 1'b1; s_a = 8'(k * 17); s_b = 8'(k * 17); s_tag = 5'(k);
        end
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_count", s_taken, 3'd7);
        check("sat_idle", s_out_valid, 1'b0);
        s_in_valid = 1'b1; s_tag = 5'd30;
        @(posedge clk); #1;
        s_tag = 5'd31;
        @(posedge clk); #1;
        s_reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_count", s_taken, 3'd0);
        check("rst_mid_valid", s_out_valid, 1'b0);
        check("rst_mid_ready", s_in_ready, 1'b0);
        s_reset = 1'b0; s_in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_mid_no_ghost", s_out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
